// File: rtl/adder_bist_if.sv
// BIST controller <-> adder-under-test signal bundle.
// The master modport belongs to the BIST controller. The slave modport belongs to the adder/observer side.
interface adder_bist_if;
   logic       start;
   logic [3:0] A_out;
   logic [3:0] B_out;
   logic       C0_out;
   logic [3:0] S_in;
   logic       C4_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [9:0] err_cnt;
   logic       fail_valid;
   logic [8:0] first_fail;

   modport master (
      input  start, S_in, C4_in,
      output A_out, B_out, C0_out, busy, done, pass, err_cnt, fail_valid, first_fail
   );

   modport slave (
      output start, S_in, C4_in,
      input  A_out, B_out, C0_out, busy, done, pass, err_cnt, fail_valid, first_fail
   );
endinterface

// File: rtl/adder_bist.sv
// Exhaustive 512-vector BIST sweep of an external 4-bit adder.
// Each vector takes LAT+2 cycles. start is ignored while busy. Define ADDER_BIST_CAPTURE_EN to record the first failing index.
module adder_bist #(
   parameter int unsigned LAT = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_bist_if.master io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [8:0] r_idx;
   logic [3:0] r_wait;
   logic [9:0] r_err_cnt;
   logic [4:0] w_expect;
   logic       w_mismatch;
   logic       w_start_run;

   // The operand outputs come straight from the index register, so they stay stable for the whole vector.
   assign w_expect    = {1'b0, r_idx[7:4]} + {1'b0, r_idx[3:0]} + {4'b0000, r_idx[8]};
   assign w_mismatch  = ({io_bus.C4_in, io_bus.S_in} != w_expect);
   assign w_start_run = ((r_state == S_IDLE) || (r_state == S_DONE)) && io_bus.start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (io_bus.start) w_next = S_DRIVE;
         S_DRIVE: w_next = S_WAIT;
         S_WAIT:  if (r_wait == 4'd0) w_next = S_CHECK;
         S_CHECK: w_next = (r_idx == 9'h1FF) ? S_DONE : S_DRIVE;
         S_DONE:  if (io_bus.start) w_next = S_DRIVE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= 9'd0;
         r_wait    <= 4'd0;
         r_err_cnt <= 10'd0;
      end else begin
         r_state <= w_next;
         if (w_start_run) begin
            r_idx     <= 9'd0;
            r_err_cnt <= 10'd0;
         end
         case (r_state)
            S_DRIVE: r_wait <= 4'(LAT - 1);
            S_WAIT:  if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
            S_CHECK: begin
               if (w_mismatch) r_err_cnt <= r_err_cnt + 10'd1;
               if (r_idx != 9'h1FF) r_idx <= r_idx + 9'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef ADDER_BIST_CAPTURE_EN
   logic       r_fail_valid;
   logic [8:0] r_first_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fail_valid <= 1'b0;
         r_first_fail <= 9'd0;
      end else if (w_start_run) begin
         r_fail_valid <= 1'b0;
         r_first_fail <= 9'd0;
      end else if ((r_state == S_CHECK) && w_mismatch && !r_fail_valid) begin
         r_fail_valid <= 1'b1;
         r_first_fail <= r_idx;
      end
   end

   assign io_bus.fail_valid = r_fail_valid;
   assign io_bus.first_fail = r_first_fail;
`else
   assign io_bus.fail_valid = 1'b0;
   assign io_bus.first_fail = 9'd0;
`endif

   assign io_bus.C0_out  = r_idx[8];
   assign io_bus.A_out   = r_idx[7:4];
   assign io_bus.B_out   = r_idx[3:0];
   assign io_bus.busy    = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
   assign io_bus.done    = (r_state == S_DONE);
   assign io_bus.pass    = (r_state == S_DONE) && (r_err_cnt == 10'd0);
   assign io_bus.err_cnt = r_err_cnt;

endmodule
